img_ram_writer: RTL
===================

// Module: img_ram_writer
// PURPOSE
//  Write-side counterpart of the picture ROM readers in the HDMI picture/char overlay design.
//  Accepts a byte stream (e.g. from UART RX), packs bytes MSB-first into DATA_WIDTH-bit pixels,
//  and drives the write port of a simple dual-port picture RAM. The HDMI timing side reads that RAM.
//  Frames are delimited by a start-of-frame pulse. Completion and protocol errors are flagged.
// PARAMETERS
//  ADDR_WIDTH  16     RAM address width; IMG_PIXELS <= 2**ADDR_WIDTH
//  DATA_WIDTH  24     pixel width, multiple of 8; BYTES = DATA_WIDTH/8 (default 3: R,G,B)
//  IMG_PIXELS  40000  pixels per frame (200x200); last address = IMG_PIXELS-1
// PORTS
//  clk         in   1           clock; all logic on posedge
//  rst         in   1           reset, asynchronous, active-high
//  sof_i       in   1           start-of-frame pulse; (re)starts a frame at address 0
//  s_valid     in   1           input byte valid
//  s_data      in   8           input byte
//  s_ready     out  1           byte accepted when s_valid & s_ready
//  wr_en       out  1           RAM write strobe, one cycle per pixel
//  wr_addr     out  ADDR_WIDTH  RAM write address
//  wr_data     out  DATA_WIDTH  RAM write data
//  busy        out  1           high while in RECV
//  frame_done  out  1           one-cycle pulse with the write of pixel IMG_PIXELS-1
//  err_sof     out  1           one-cycle pulse: sof_i arrived mid-frame (frame aborted)
// BEHAVIOUR
//  Reset: state IDLE; byte_cnt=0, pix_cnt=0, shift reg=0.
//   All registered outputs (wr_en, wr_addr, wr_data, frame_done, err_sof) = 0. busy=0, s_ready=0.
//  s_ready = (state==RECV) & ~sof_i  (combinational). busy = (state==RECV).
//  FSM: IDLE --sof_i--> RECV.
//   RECV --sof_i--> RECV, restarted: byte_cnt=0, pix_cnt=0; err_sof=1 next cycle
//     if byte_cnt!=0 or pix_cnt!=0.
//   RECV --last pixel packed--> IDLE.
//  IDLE: bytes are not accepted (s_ready=0). s_valid is ignored. No writes.
//  Packing: the first byte of a pixel goes to wr_data[DATA_WIDTH-1 -: 8], the last to [7:0].
//   byte_cnt counts 0..BYTES-1 on each accepted byte and wraps to 0 on the BYTES-th byte.
//  Write: on the cycle after the BYTES-th byte is accepted, drive the following for exactly 1 cycle:
//   wr_en=1, wr_addr=pix_cnt, wr_data=packed pixel. pix_cnt then increments.
//  wr_addr/wr_data hold their last values when wr_en=0.
//  Latency: last byte accepted at cycle N -> wr_en at N+1.
//   Throughput is 1 byte/cycle; back-to-back pixels are allowed.
//  End of frame: when the byte completing pixel IMG_PIXELS-1 is accepted:
//   - state returns to IDLE (s_ready drops at N+1)
//   - wr_en and frame_done are both high at N+1
//   - pix_cnt returns to 0; no address wrap beyond IMG_PIXELS-1
//  s_valid gaps (valid low) simply stall packing. There is no timeout. Partial pixels are retained.
//  Simultaneous sof_i & s_valid in RECV: sof_i wins and the byte is not accepted (s_ready=0).
//   A pending wr_en from the previous cycle still completes.
//  sof_i in the same cycle as frame completion (last byte accepted): the frame completes normally.
//   frame_done=1, err_sof=0; sof_i is treated as the start of the next frame and state stays RECV.
//   Note: s_ready=0 in that cycle, so the last byte cannot be accepted together with sof_i.
//   Completion therefore implies sof_i was low; the rule only matters for a following sof.
//  Reset mid-frame: all state is cleared immediately and no wr_en is issued after rst asserts.
//   RAM contents are not modified.
// TESTING
//  1 IMG_PIXELS=4: sof, 12 bytes 01..0C back-to-back.
//    -> wr_en at addrs 0..3 with 010203, 040506, 0708 09, 0A0B0C.
//    -> frame_done with addr 3; then IDLE, s_ready=0.
//  2 Same frame with random 0-5 cycle s_valid gaps.
//    -> identical write sequence; wr_en exactly 4 times, 1 cycle each.
//  3 sof, 5 bytes (AA..EE), then sof.
//    -> one write AABBCC@0; err_sof pulse; next 12 bytes write addrs 0..3 correctly.
//  4 s_valid with byte 55 while IDLE (no sof).
//    -> s_ready=0, no wr_en. A later sof+frame writes from addr 0.
//  5 sof_i & s_valid same cycle in RECV after 2 bytes.
//    -> byte not taken, err_sof=1, byte_cnt reset (next 3 bytes form pixel @0).
//  6 rst asserted after 7 of 12 bytes.
//    -> outputs 0 immediately, no further writes; after release and sof, frame writes from addr 0.

Source files
------------

// File: rtl/img_ram_writer.sv
// Packs an incoming byte stream MSB-first into pixels and writes them to the
// picture RAM, one frame per start-of-frame pulse.
module img_ram_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_PIXELS = 40000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof_i,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_sof
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(IMG_PIXELS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_sof_q, err_sof_d;
  logic [DATA_WIDTH-1:0] packed_pix;

  // sof_i always wins over a byte presented in the same cycle
  assign s_ready    = (state_q == RECV) & ~sof_i;
  assign busy       = (state_q == RECV);
  assign packed_pix = (shift_q << 8) | DATA_WIDTH'(s_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      shift_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      shift_q      <= shift_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    shift_d      = shift_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_sof_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sof_i) begin
          state_d    = RECV;
          byte_cnt_d = '0;
          pix_cnt_d  = '0;
          shift_d    = '0;
        end
      end
      RECV: begin
        if (sof_i) begin
          // Restart: only flag an error if the aborted frame had any progress
          err_sof_d  = (byte_cnt_q != '0) || (pix_cnt_q != '0);
          byte_cnt_d = '0;
          pix_cnt_d  = '0;
          shift_d    = '0;
        end else if (s_valid) begin
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            shift_d    = '0;
            wr_en_d    = 1'b1;
            wr_addr_d  = pix_cnt_q;
            wr_data_d  = packed_pix;
            if (pix_cnt_q == LAST_PIX) begin
              pix_cnt_d    = '0;
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            shift_d    = packed_pix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign err_sof    = err_sof_q;

endmodule
